multicycle_main_control: RTL and testbench

//  Main control FSM for the multi-cycle RISC-V core; sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction.

---
 rtl/multicycle_main_control.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RISC-V core: sequences fetch/decode/execute/memory/writeback
// and owns the req/ready handshake to the unified memory, with a wait timeout into a sticky trap.
module multicycle_main_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALU_Op,
    output logic [3:0] state,
    output logic       instret,
    output logic       illegal_instr,
    output logic       bus_error
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // A zero timeout still gets a 1-bit counter so the declarations stay legal.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LIM = CW'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    state_t         cur_state, next_state;
    logic [CW-1:0]  wait_cnt, wait_cnt_next;
    logic           illegal_q, bus_error_q;
    logic           is_wait, timeout_hit, set_illegal;

    assign is_wait     = (cur_state == S_FETCH) || (cur_state == S_MEMREAD) ||
                         (cur_state == S_MEMWRITE);
    // A ready arriving on the limit cycle still completes the access.
    assign timeout_hit = (MEM_TIMEOUT != 0) && is_wait && !mem_ready && (wait_cnt == CNT_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= S_IDLE;
            wait_cnt    <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            cur_state <= next_state;
            wait_cnt  <= wait_cnt_next;
            if (set_illegal) illegal_q <= 1'b1;
            if (timeout_hit) bus_error_q <= 1'b1;
        end
    end

    // Counter is zero outside a wait, so every wait state is entered with a clear count.
    always_comb begin
        wait_cnt_next = '0;
        if (is_wait && !mem_ready && !timeout_hit)
            wait_cnt_next = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    end

    always_comb begin
        next_state  = cur_state;
        set_illegal = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        AdrSrc      = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALU_Op      = 2'b00;
        instret     = 1'b0;
        case (cur_state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready)        next_state = S_DECODE;
                else if (timeout_hit) next_state = S_TRAP;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default: begin
                        next_state  = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready)        next_state = S_MEMWB;
                else if (timeout_hit) next_state = S_TRAP;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                ResultSrc  = 2'b01;
                instret    = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                AdrSrc  = 1'b1;
                instret = mem_ready;
                if (mem_ready)        next_state = S_FETCH;
                else if (timeout_hit) next_state = S_TRAP;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALU_Op     = 2'b10;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instret    = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALU_Op     = 2'b01;
                PCWrite    = zero;
                instret    = 1'b1;
                next_state = S_FETCH;
            end
            // PC takes the target from ALUOut while the ALU forms OldPC+4 as the link value.
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCWrite    = 1'b1;
                next_state = S_ALUWB;
            end
            S_TRAP: next_state = S_TRAP;
            default: next_state = S_TRAP;
        endcase
    end

    assign state         = cur_state;
    assign illegal_instr = illegal_q;
    assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: instruction-level reference model pushes per-cycle expected
// controls into a scoreboard queue; a negedge monitor pops and compares against the DUT.
module tb_multicycle_main_control;

    localparam int MEM_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALU_Op;
    logic [3:0] state;
    logic       instret, illegal_instr, bus_error;

    multicycle_main_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALU_Op(ALU_Op), .state(state), .instret(instret),
        .illegal_instr(illegal_instr), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, adr, irw, pcw, regw;
        logic [1:0] srca, srcb, res, aluop;
        logic       instret, ill, berr;
    } rec_t;

    rec_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    ill_m = 0;
    bit    berr_m = 0;

    // ---------------- reference model: per-phase control expectations ----------------
    function automatic rec_t base(input logic [3:0] st);
        rec_t r;
        r = '0;
        r.st = st; r.ill = ill_m; r.berr = berr_m;
        return r;
    endfunction

    function automatic rec_t r_mem(input int which, input logic rdy);
        rec_t r;
        r = base(4'(which));
        r.mem_req = 1'b1;
        if (which == 1) begin
            r.srcb = 2'b10; r.res = 2'b10; r.irw = rdy; r.pcw = rdy;
        end else begin
            r.adr = 1'b1;
            if (which == 6) begin r.mem_we = 1'b1; r.instret = rdy; end
        end
        return r;
    endfunction

    function automatic rec_t r_phase(input int which, input logic z);
        rec_t r;
        r = base(4'(which));
        case (which)
            2:  begin r.srca = 2'b01; r.srcb = 2'b01; end
            3:  begin r.srca = 2'b10; r.srcb = 2'b01; end
            5:  begin r.regw = 1'b1; r.res = 2'b01; r.instret = 1'b1; end
            7:  begin r.srca = 2'b10; r.aluop = 2'b10; end
            8:  begin r.regw = 1'b1; r.instret = 1'b1; end
            9:  begin r.srca = 2'b10; r.aluop = 2'b01; r.pcw = z; r.instret = 1'b1; end
            10: begin r.srca = 2'b01; r.srcb = 2'b10; r.pcw = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [6:0] op_of(input int kind);
        logic [6:0] o;
        case (kind)
            0: o = 7'b0110011;
            1: o = 7'b0000011;
            2: o = 7'b0100011;
            3: o = 7'b1100011;
            4: o = 7'b1101111;
            default: begin
                o = 7'($urandom);
                while (o == 7'b0110011 || o == 7'b0000011 || o == 7'b0100011 ||
                       o == 7'b1100011 || o == 7'b1101111)
                    o = 7'($urandom);
            end
        endcase
        return o;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input rec_t r, input string tag, input logic rdy, input logic z,
                        input logic rst, input bit chk);
        mem_ready = rdy; zero = z; reset = rst;
        if (chk) begin exp_q.push_back(r); tag_q.push_back(tag); end
        @(posedge clk); #1;
    endtask

    task automatic mem_phase(input int which, input int lat, output bit to);
        to = 1'b0;
        if (lat > MEM_TIMEOUT) begin
            for (int i = 0; i <= MEM_TIMEOUT; i++)
                step(r_mem(which, 1'b0), "mem_wait_to", 1'b0, 1'($urandom), 1'b0, 1'b1);
            berr_m = 1'b1;
            to = 1'b1;
        end else begin
            for (int i = 0; i < lat; i++)
                step(r_mem(which, 1'b0), "mem_wait", 1'b0, 1'($urandom), 1'b0, 1'b1);
            step(r_mem(which, 1'b1), "mem_done", 1'b1, 1'($urandom), 1'b0, 1'b1);
        end
    endtask

    task automatic trap_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            opcode = 7'($urandom);
            step(base(4'd15), "trap", 1'($urandom), 1'($urandom), 1'b0, 1'b1);
        end
    endtask

    task automatic recover();
        step(base(4'd15), "trap_in_rst", 1'($urandom), 1'($urandom), 1'b1, 1'b1);
        ill_m = 1'b0; berr_m = 1'b0;
        step(base(4'd0), "idle_after_rst", 1'($urandom), 1'($urandom), 1'b0, 1'b1);
    endtask

    task automatic run_instr(input int kind, input int flat, input int dlat, input logic z);
        bit to;
        opcode = op_of(kind);
        mem_phase(1, flat, to);
        if (!to) begin
            step(r_phase(2, 1'b0), "decode", 1'($urandom), 1'($urandom), 1'b0, 1'b1);
            case (kind)
                0: begin
                    step(r_phase(7, 1'b0), "execr", 1'($urandom), 1'($urandom), 1'b0, 1'b1);
                    step(r_phase(8, 1'b0), "aluwb", 1'($urandom), 1'($urandom), 1'b0, 1'b1);
                end
                1: begin
                    step(r_phase(3, 1'b0), "memadr_lw", 1'($urandom), 1'($urandom), 1'b0, 1'b1);
                    mem_phase(4, dlat, to);
                    if (!to) step(r_phase(5, 1'b0), "memwb", 1'($urandom), 1'($urandom), 1'b0, 1'b1);
                end
                2: begin
                    step(r_phase(3, 1'b0), "memadr_sw", 1'($urandom), 1'($urandom), 1'b0, 1'b1);
                    mem_phase(6, dlat, to);
                end
                3: step(r_phase(9, z), "beq", 1'($urandom), z, 1'b0, 1'b1);
                4: begin
                    step(r_phase(10, 1'b0), "jal", 1'($urandom), 1'($urandom), 1'b0, 1'b1);
                    step(r_phase(8, 1'b0), "jal_wb", 1'($urandom), 1'($urandom), 1'b0, 1'b1);
                end
                default: begin
                    ill_m = 1'b1;
                    to = 1'b1;
                end
            endcase
        end
        if (to) begin
            trap_cycles(int'($urandom_range(1, 5)));
            recover();
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        rec_t  e, a;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = '{state, mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite,
                      ALUSrcA, ALUSrcB, ResultSrc, ALU_Op, instret, illegal_instr, bus_error};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got %h required %h", t, $time, a, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit to;
        // reset held two cycles; the first edge establishes IDLE
        step(base(4'd0), "rst0", 1'b0, 1'b0, 1'b1, 1'b0);
        step(base(4'd0), "rst_idle", 1'b1, 1'b1, 1'b1, 1'b1);
        step(base(4'd0), "release_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        run_instr(0, 0, 0, 1'b0);           // R-type, immediate fetch
        run_instr(1, 1, 3, 1'b0);           // lw, read ready 3 cycles late
        run_instr(3, 0, 0, 1'b1);           // beq taken
        run_instr(3, 2, 0, 1'b0);           // beq not taken
        run_instr(4, 0, 0, 1'b0);           // jal
        run_instr(2, 0, 2, 1'b0);           // sw

        opcode = 7'b1111111;                // illegal opcode, long trap
        mem_phase(1, 0, to);
        step(r_phase(2, 1'b0), "decode_ill", 1'b0, 1'b0, 1'b0, 1'b1);
        ill_m = 1'b1;
        trap_cycles(20);
        recover();

        run_instr(0, MEM_TIMEOUT + 1, 0, 1'b0);   // fetch timeout
        run_instr(0, MEM_TIMEOUT, 0, 1'b0);       // ready on the limit cycle wins
        run_instr(1, 0, MEM_TIMEOUT + 1, 1'b0);   // read timeout
        run_instr(2, 0, MEM_TIMEOUT, 1'b0);       // write ready on the limit cycle

        opcode = op_of(2);                  // reset in the middle of a store wait
        mem_phase(1, 0, to);
        step(r_phase(2, 1'b0), "decode_sw", 1'b0, 1'b0, 1'b0, 1'b1);
        step(r_phase(3, 1'b0), "memadr_sw", 1'b0, 1'b0, 1'b0, 1'b1);
        step(r_mem(6, 1'b0), "memwrite_wait", 1'b0, 1'b0, 1'b0, 1'b1);
        step(r_mem(6, 1'b0), "memwrite_in_rst", 1'b0, 1'b0, 1'b1, 1'b1);
        step(base(4'd0), "idle_after_mw_rst", 1'b1, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 200; i++) begin
            int kind, flat, dlat;
            kind = int'($urandom_range(0, 12));
            if (kind > 5) kind = kind % 5;
            flat = ($urandom_range(0, 19) == 0) ? MEM_TIMEOUT + 1 : int'($urandom_range(0, 4));
            dlat = ($urandom_range(0, 14) == 0) ? MEM_TIMEOUT + 1 : int'($urandom_range(0, 4));
            run_instr(kind, flat, dlat, 1'($urandom));
        end

        @(negedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
